// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling, glitch-start
// rejection, and one-cycle data_ready / framing_error pulses.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 87
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] received_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       is_receiving
);

  localparam logic [7:0] HALF     = 8'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [7:0] BIT_LAST = 8'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CLEANUP
  } state_t;

  state_t     state;
  logic [7:0] counter;
  logic [2:0] index;
  logic [7:0] shift;
  logic       sync_meta;
  logic       rx_sync;

  // Synchronizer presets to the idle (high) line level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_sync   <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      rx_sync   <= sync_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      index         <= '0;
      shift         <= '0;
      received_data <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      is_receiving  <= 1'b0;
    end else begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          counter      <= '0;
          index        <= '0;
          is_receiving <= 1'b0;
          if (!rx_sync) begin
            state        <= START_BIT;
            is_receiving <= 1'b1;
          end
        end
        START_BIT: begin
          if (counter < HALF) begin
            counter <= counter + 8'd1;
          end else begin
            counter <= '0;
            if (!rx_sync) begin
              state <= DATA_BITS;
            end else begin
              state        <= IDLE;
              is_receiving <= 1'b0;
            end
          end
        end
        DATA_BITS: begin
          if (counter < BIT_LAST) begin
            counter <= counter + 8'd1;
          end else begin
            counter       <= '0;
            shift[index]  <= rx_sync;
            if (index != 3'd7) begin
              index <= index + 3'd1;
            end else begin
              index <= '0;
              state <= STOP_BIT;
            end
          end
        end
        STOP_BIT: begin
          if (counter < BIT_LAST) begin
            counter <= counter + 8'd1;
          end else begin
            counter      <= '0;
            is_receiving <= 1'b0;
            state        <= CLEANUP;
            if (rx_sync) begin
              received_data <= shift;
              data_ready    <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
          end
        end
        CLEANUP: begin
          // Waiting for a high line keeps a held-low break from re-triggering.
          counter <= '0;
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          counter      <= '0;
          index        <= '0;
          is_receiving <= 1'b0;
        end
      endcase
    end
  end

endmodule
